// File: rtl/eeprom_top.sv
// Serial EEPROM master with a built-in 128 x 8 memory model acting as the slave.
// Each bit spans 4 clocks: phase0 scl low/sda update, phase1-2 scl high (sample in 2), phase3 low.
module eeprom_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       ack,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic [6:0] addr,
    output logic       scl,
    inout  wire        sda,
    output logic [7:0] rdata,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle, StStart, StAddr, StAck1, StData, StAck2, StStop, StDone
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [6:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  shift_q;
    logic        ack_q;
    logic [7:0]  rdata_q;
    logic [7:0]  mem [128];

    logic [1:0]  phase;
    logic [2:0]  bit_idx;
    logic        last4;
    logic        last32;
    logic        bit_scl;
    logic        sda_en;
    logic        sda_drv;
    logic        mem_en;
    logic        mem_bit;

    assign phase   = cnt_q[1:0];
    assign bit_idx = cnt_q[4:2];
    assign last4   = (cnt_q == 5'd3);
    assign last32  = (cnt_q == 5'd31);
    assign bit_scl = phase[0] ^ phase[1];
    assign mem_bit = mem[addr_q][3'd7 - bit_idx];
    assign rdata   = rdata_q;

    // Master and memory model enables are mutually exclusive by state decode.
    assign sda = sda_en ? sda_drv : (mem_en ? mem_bit : 1'bz);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        scl     = 1'b1;
        sda_en  = 1'b1;
        sda_drv = 1'b1;
        mem_en  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 5'd0;
                if (newd) state_d = StStart;
            end
            StStart: begin
                sda_drv = ~phase[1];
                if (last4) begin
                    state_d = StAddr;
                    cnt_d   = 5'd0;
                end
            end
            StAddr: begin
                scl     = bit_scl;
                sda_drv = (bit_idx == 3'd7) ? ~wr_q : addr_q[3'd6 - bit_idx];
                if (last32) begin
                    state_d = StAck1;
                    cnt_d   = 5'd0;
                end
            end
            StAck1: begin
                scl    = bit_scl;
                sda_en = 1'b0;
                if (last4) begin
                    state_d = ack_q ? StData : StStop;
                    cnt_d   = 5'd0;
                end
            end
            StData: begin
                scl = bit_scl;
                if (wr_q) begin
                    sda_drv = wdata_q[3'd7 - bit_idx];
                end else begin
                    sda_en = 1'b0;
                    mem_en = 1'b1;
                end
                if (last32) begin
                    state_d = StAck2;
                    cnt_d   = 5'd0;
                end
            end
            StAck2: begin
                // Write: slave acknowledges; read: master sends NACK.
                scl    = bit_scl;
                sda_en = ~wr_q;
                if (last4) begin
                    state_d = StStop;
                    cnt_d   = 5'd0;
                end
            end
            StStop: begin
                scl     = (phase != 2'd0);
                sda_drv = phase[1];
                if (last4) begin
                    state_d = StDone;
                    cnt_d   = 5'd0;
                end
            end
            StDone: begin
                done    = 1'b1;
                cnt_d   = 5'd0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = 5'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            wr_q    <= 1'b0;
            addr_q  <= 7'd0;
            wdata_q <= 8'h00;
            shift_q <= 8'h00;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && newd) begin
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (phase == 2'd2) begin
                if (state_q == StAck1) ack_q <= ack;
                if (state_q == StData && !wr_q) shift_q <= {shift_q[6:0], sda};
            end
            if (state_q == StAck2 && !wr_q && last4) rdata_q <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else if (state_q == StAck2 && wr_q && phase == 2'd2 && ack) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_eeprom_top.sv
// Bench for eeprom_top: a waveform-level transaction model feeds an expectation queue that a
// single negedge compare process checks every cycle, plus literal checks on timing and data.
module tb_eeprom_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       newd;
    logic       ack;
    logic       wr;
    logic [7:0] wdata;
    logic [6:0] addr;
    logic       scl;
    wire        sda;
    logic [7:0] rdata;
    logic       done;

    eeprom_top dut (
        .clk  (clk),
        .rst  (rst),
        .newd (newd),
        .ack  (ack),
        .wr   (wr),
        .wdata(wdata),
        .addr (addr),
        .scl  (scl),
        .sda  (sda),
        .rdata(rdata),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       scl;
        logic       sda;
        logic       sda_chk;
        logic       done;
        logic [7:0] rdata;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mem_m [128];
    logic [7:0] model_rdata;
    logic [7:0] cur_rdata;
    int         n_total = 0;
    int         n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
        model_rdata = 8'h00;
        expq.delete();
    endtask

    task automatic push(input logic c, input logic s, input logic k, input logic dn);
        exp_t e;
        e.scl = c; e.sda = s; e.sda_chk = k; e.done = dn; e.rdata = cur_rdata;
        expq.push_back(e);
    endtask

    // One bit slot; k=0 means sda is not driven by anyone we can predict.
    task automatic slot(input logic b, input logic k);
        push(1'b0, b, k, 1'b0);
        push(1'b1, b, k, 1'b0);
        push(1'b1, b, k, 1'b0);
        push(1'b0, b, k, 1'b0);
    endtask

    task automatic build(input logic w, input logic [6:0] a, input logic [7:0] d, input logic k);
        cur_rdata = model_rdata;
        push(1'b1, 1'b1, 1'b1, 1'b0); push(1'b1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0); push(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 6; i >= 0; i--) slot(a[i], 1'b1);
        slot(~w, 1'b1);
        slot(1'b0, 1'b0);
        if (k) begin
            if (w) begin
                for (int i = 7; i >= 0; i--) slot(d[i], 1'b1);
                slot(1'b0, 1'b0);
                mem_m[a] = d;
            end else begin
                for (int i = 7; i >= 0; i--) slot(mem_m[a][i], 1'b1);
                slot(1'b1, 1'b1);
                cur_rdata = mem_m[a];
            end
        end
        push(1'b0, 1'b0, 1'b1, 1'b0); push(1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b0); push(1'b1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b1);
        model_rdata = cur_rdata;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic s;
        if (rst) begin
            check("reset_outputs", {21'd0, scl, sda, done, rdata}, {21'd0, 1'b1, 1'b1, 1'b0, 8'h00});
        end else if (expq.size() > 0) begin
            e = expq.pop_front();
            s = e.sda_chk ? sda : e.sda;
            check("txn_cycle", {21'd0, scl, s, done, rdata}, {21'd0, e.scl, e.sda, e.done, e.rdata});
        end else begin
            check("idle_cycle", {21'd0, scl, sda, done, rdata},
                  {21'd0, 1'b1, 1'b1, 1'b0, model_rdata});
        end
    end

    task automatic run(input logic w, input logic [6:0] a, input logic [7:0] d, input logic k,
                       input int mid_pulse, input int rst_at,
                       output int done_cyc, output int n_done);
        @(posedge clk);
        #1 newd = 1'b1; wr = w; addr = a; wdata = d; ack = k;
        @(posedge clk);
        // Scramble captured inputs to prove the latched copies are used.
        #1 newd = 1'b0; wr = ~w; addr = ~a; wdata = ~d;
        build(w, a, d, k);
        done_cyc = 0;
        n_done   = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == mid_pulse) newd = 1'b1;
            else if (c == mid_pulse + 2) newd = 1'b0;
            if (c == rst_at) begin
                @(posedge clk);
                #1 rst = 1'b1;
                model_reset();
                #1;
                check("rst_immediate", {29'd0, scl, sda, done}, {29'd0, 1'b1, 1'b1, 1'b0});
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
                break;
            end
        end
        if (rst_at == 0) check("queue_drained", expq.size(), 0);
    endtask

    int dc, nd;

    initial begin
        rst = 1'b1; newd = 1'b0; ack = 1'b0; wr = 1'b0; wdata = 8'h00; addr = 7'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run(1'b1, 7'h55, 8'hAA, 1'b1, 0, 0, dc, nd);
        check("write_done_cycle", dc, 81);
        check("write_done_count", nd, 1);

        run(1'b0, 7'h55, 8'h00, 1'b1, 0, 0, dc, nd);
        check("read_done_cycle", dc, 81);
        check("read_55_rdata", {24'd0, rdata}, {24'd0, 8'hAA});

        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(1'b0, 7'h10, 8'h00, 1'b1, 0, 0, dc, nd);
        check("read_unwritten_rdata", {24'd0, rdata}, {24'd0, 8'h00});

        run(1'b1, 7'h10, 8'h3C, 1'b1, 0, 0, dc, nd);
        run(1'b1, 7'h10, 8'hFF, 1'b0, 0, 0, dc, nd);
        check("abort_done_cycle", dc, 45);
        check("abort_done_count", nd, 1);
        run(1'b0, 7'h10, 8'h00, 1'b1, 0, 0, dc, nd);
        check("after_abort_rdata", {24'd0, rdata}, {24'd0, 8'h3C});

        run(1'b1, 7'h20, 8'h5A, 1'b1, 30, 0, dc, nd);
        check("midnewd_done_cycle", dc, 81);
        check("midnewd_done_count", nd, 1);
        run(1'b0, 7'h20, 8'h00, 1'b1, 0, 0, dc, nd);
        check("midnewd_read_rdata", {24'd0, rdata}, {24'd0, 8'h5A});

        run(1'b1, 7'h20, 8'hC3, 1'b1, 0, 20, dc, nd);
        check("rst_abort_no_done", nd, 0);
        run(1'b0, 7'h20, 8'h00, 1'b1, 0, 0, dc, nd);
        check("rst_abort_read_rdata", {24'd0, rdata}, {24'd0, 8'h00});

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eeprom_top.md
EEPROM_TOP -- requirements
Module: eeprom_top

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 newd  input  1  start request; sampled only in IDLE.
REQ-004 ack  input  1  slave-acknowledge qualifier; 1 = ACK, 0 = NACK; sampled at acknowledge slots.
REQ-005 wr  input  1  operation select; 1 = write, 0 = read; captured with newd.
REQ-006 wdata  input  8  write data byte; captured with newd.
REQ-007 addr  input  7  memory/device address; captured with newd.
REQ-008 scl  output  1  serial clock generated by the master.
REQ-009 sda  inout  1  serial data; driven by the master except during the read-data byte, when the internal memory model drives it.
REQ-010 rdata  output  8  last byte read.
REQ-011 done  output  1  one-cycle pulse at end of every transaction, including aborted ones.

Function
REQ-012 The block SHALL contain a serial master and an internal 128 x 8 memory model, indexed by addr, acting as the EEPROM slave.
REQ-013 In IDLE with newd=1 on a clock edge, the block SHALL latch addr, wdata and wr, then enter START; newd SHALL be ignored in all other states.
REQ-014 Bit timing SHALL be 4 clk per bit: phase0 scl=0 with sda update; phase1 scl=1; phase2 scl=1 with sda sample; phase3 scl=0.
REQ-015 START (4 clk) SHALL take sda from 1 to 0 while scl=1.
REQ-016 ADDR (32 clk) SHALL shift addr[6:0] MSB first, then the R/W bit (0 = write, 1 = read, i.e. ~wr).
REQ-017 ACK1 (4 clk): the master SHALL release sda; ack=1 at phase2 SHALL continue; ack=0 SHALL go to STOP with no memory or rdata change.
REQ-018 Write path: WDATA (32 clk) SHALL shift wdata MSB first.
REQ-019 Write path: ACK2 (4 clk) SHALL write mem[addr] <= wdata only when ack=1 at phase2.
REQ-020 Read path: RDATA (32 clk) SHALL have the memory model drive mem[addr] MSB first on sda, with the master sampling at phase2.
REQ-021 Read path: ACK2 SHALL have the master drive NACK (sda=1), and the sampled byte SHALL load rdata at the end of ACK2.
REQ-022 STOP (4 clk) SHALL take sda from 0 to 1 while scl=1, then enter DONE.
REQ-023 DONE SHALL assert done for exactly one clk, then return to IDLE.
REQ-024 A full transaction SHALL assert done on the 81st clk after the edge that sampled newd (4+32+4+32+4+4 = 80 cycles, plus DONE).
REQ-025 An ACK1 abort SHALL shorten the sequence: START+ADDR+ACK1+STOP then DONE, with done on the 45th clk.
REQ-026 In IDLE, scl=1 and sda is driven 1; sda SHALL never be driven simultaneously by master and memory model.
REQ-027 The latched wr, addr and wdata SHALL stay constant during a transaction regardless of input changes.

Reset
REQ-028 While rst=1: state IDLE, scl=1, sda driven 1, done=0, rdata=8'h00, and all memory locations = 8'h00.
REQ-029 Reset asserted mid-transaction SHALL abort immediately, with no memory write and no done pulse.

Verification
REQ-030 Reset, then write addr=7'h55, wdata=8'hAA, ack=1 -> START, address bits 1010101 then 0, data 10101010 on sda; mem[55h]=AAh; done pulse 81 clk after newd.
REQ-031 Then read addr=7'h55, wr=0, ack=1 -> R/W bit 1, sda carries 10101010 from the memory model; rdata=8'hAA at done.
REQ-032 Read of an unwritten address (7'h10) after reset -> rdata=8'h00.
REQ-033 Write with ack=0 throughout -> abort after ACK1, done at 45th clk, memory unchanged.
REQ-034 newd pulsed during an active transaction -> ignored; exactly one done pulse.
REQ-035 rst asserted at cycle 20 of a write -> scl=1, sda=1, done=0 immediately; target location unchanged.
